// File: rtl/mc_control.sv
// mc_control: multi-cycle main control FSM for the MIPS datapath.
// Each instruction is sequenced through FETCH/DECODE/EXEC/MEM/WB-style states
// with a ready handshake to the shared memory. All outputs are decoded from the
// state register and the instruction fields latched in DECODE.
// Build option: define MC_CONTROL_MULDIV_EN to sequence MULT/DIV through the
// MULDIV wait state; otherwise MULT/DIV are treated as illegal instructions.
module mc_control #(
  parameter int ALU_OP_W      = 6,
  parameter int MULDIV_CYCLES = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          func,
  input  logic [4:0]          rt,
  input  logic                mem_ready,
  input  logic                alu_zero,
  input  logic                alu_neg,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_byte,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          wb_sel,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                hilo_write,
  output logic                halt,
  output logic                illegal,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEM_RD = 4'd3,
    S_MEM_WR = 4'd4,
    S_WB_ALU = 4'd5,
    S_WB_MEM = 4'd6,
    S_BRANCH = 4'd7,
    S_JUMP   = 4'd8,
    S_MULDIV = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SW     = 6'b101011;

  // R-type functs of special interest
  localparam logic [5:0] FN_SYSCALL = 6'b001100;
  localparam logic [5:0] FN_MULT    = 6'b011000;
  localparam logic [5:0] FN_DIV     = 6'b011010;

  // ALU operation codes (equal to the MIPS funct values)
  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_ADDU = 6'b100001;
  localparam logic [5:0] ALU_SUB  = 6'b100010;
  localparam logic [5:0] ALU_AND  = 6'b100100;
  localparam logic [5:0] ALU_OR   = 6'b100101;
  localparam logic [5:0] ALU_XOR  = 6'b100110;
  localparam logic [5:0] ALU_SLT  = 6'b101010;

  localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  state_t           cur_state;
  state_t           next_state;
  logic [5:0]       op_q;
  logic [5:0]       func_q;
  logic [4:0]       rt_q;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       alu_code;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LB);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SB);
  endfunction

  function automatic logic is_ialu(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI) ||
           (op == OP_ANDI) || (op == OP_ORI)   || (op == OP_XORI) ||
           (op == OP_LUI);
  endfunction

  function automatic logic is_branch(input logic [5:0] op, input logic [4:0] r);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) ||
           (op == OP_BGTZ) || ((op == OP_REGIMM) && (r == 5'b00001));
  endfunction

  function automatic logic is_muldiv(input logic [5:0] fn);
    return (fn == FN_MULT) || (fn == FN_DIV);
  endfunction

  function automatic logic branch_taken(input logic [5:0] op, input logic z, input logic n);
    case (op)
      OP_BEQ:  return z;
      OP_BNE:  return !z;
      OP_BLEZ: return z | n;
      OP_BGTZ: return !z & !n;
      default: return !n;  // BGEZ (REGIMM, rt=00001)
    endcase
  endfunction

  // State register; reset wins over any pending memory wait
  always_ff @(posedge clk) begin
    if (!rst_n) cur_state <= S_FETCH;
    else        cur_state <= next_state;
  end

  // Latch the instruction fields while in DECODE so later states see a stable IR
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q   <= '0;
      func_q <= '0;
      rt_q   <= '0;
    end else if (cur_state == S_DECODE) begin
      op_q   <= opcode;
      func_q <= func;
      rt_q   <= rt;
    end
  end

  // MULT/DIV wait counter: loaded on entry to MULDIV, counts down to 0
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (cur_state == S_EXEC && next_state == S_MULDIV)
      cnt <= CNT_LOAD;
    else if (cur_state == S_MULDIV && cnt != '0)
      cnt <= cnt - CNT_W'(1);
  end

  // Next-state and output decode; everything forced low while reset is held
  always_comb begin
    next_state = cur_state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_byte   = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    wb_sel     = 2'd0;
    alu_src_b  = 2'd0;
    alu_code   = 6'd0;
    hilo_write = 1'b0;
    halt       = 1'b0;
    illegal    = 1'b0;

    case (cur_state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end
      end

      S_DECODE: begin
        if (opcode == OP_RTYPE) begin
          if (func == FN_SYSCALL) begin
            next_state = S_HALT;
          end else if (is_muldiv(func)) begin
`ifdef MC_CONTROL_MULDIV_EN
            next_state = S_EXEC;
`else
            illegal    = 1'b1;
            next_state = S_FETCH;
`endif
          end else begin
            next_state = S_EXEC;
          end
        end else if (is_ialu(opcode) || is_load(opcode) || is_store(opcode)) begin
          next_state = S_EXEC;
        end else if (is_branch(opcode, rt)) begin
          next_state = S_BRANCH;
        end else if (opcode == OP_J || opcode == OP_JAL) begin
          next_state = S_JUMP;
        end else begin
          illegal    = 1'b1;
          next_state = S_FETCH;
        end
      end

      S_EXEC: begin
        case (op_q)
          OP_RTYPE: begin alu_code = func_q;   alu_src_b = 2'd0; end
          OP_ADDI:  begin alu_code = ALU_ADD;  alu_src_b = 2'd1; end
          OP_ADDIU: begin alu_code = ALU_ADDU; alu_src_b = 2'd1; end
          OP_SLTI:  begin alu_code = ALU_SLT;  alu_src_b = 2'd1; end
          OP_ANDI:  begin alu_code = ALU_AND;  alu_src_b = 2'd2; end
          OP_ORI:   begin alu_code = ALU_OR;   alu_src_b = 2'd2; end
          OP_XORI:  begin alu_code = ALU_XOR;  alu_src_b = 2'd2; end
          OP_LUI:   begin alu_code = 6'd0;     alu_src_b = 2'd0; end
          default:  begin alu_code = ALU_ADD;  alu_src_b = 2'd1; end  // address calc
        endcase
        if (is_load(op_q))
          next_state = S_MEM_RD;
        else if (is_store(op_q))
          next_state = S_MEM_WR;
        else if (op_q == OP_RTYPE && is_muldiv(func_q))
          next_state = S_MULDIV;
        else
          next_state = S_WB_ALU;
      end

      S_MEM_RD: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        mem_byte = (op_q == OP_LB);
        if (mem_ready) next_state = S_WB_MEM;
      end

      S_MEM_WR: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        mem_we   = 1'b1;
        mem_byte = (op_q == OP_SB);
        if (mem_ready) next_state = S_FETCH;
      end

      S_WB_ALU: begin
        reg_write  = 1'b1;
        reg_dst    = (op_q == OP_RTYPE) ? 2'd1 : 2'd0;
        wb_sel     = (op_q == OP_LUI) ? 2'd3 : 2'd0;
        next_state = S_FETCH;
      end

      S_WB_MEM: begin
        reg_write  = 1'b1;
        reg_dst    = 2'd0;
        wb_sel     = 2'd1;
        next_state = S_FETCH;
      end

      S_BRANCH: begin
        alu_code   = ALU_SUB;
        alu_src_b  = 2'd0;
        pc_src     = 2'd1;
        pc_write   = branch_taken(op_q, alu_zero, alu_neg);
        next_state = S_FETCH;
      end

      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'd2;
        if (op_q == OP_JAL) begin
          reg_write = 1'b1;
          reg_dst   = 2'd2;
          wb_sel    = 2'd2;
        end
        next_state = S_FETCH;
      end

      S_MULDIV: begin
        alu_code = func_q;
        if (cnt == '0) begin
`ifdef MC_CONTROL_MULDIV_EN
          hilo_write = 1'b1;
`endif
          next_state = S_FETCH;
        end
      end

      S_HALT: begin
        halt = 1'b1;
      end

      default: next_state = S_FETCH;
    endcase

    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_byte   = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'd0;
      reg_write  = 1'b0;
      reg_dst    = 2'd0;
      wb_sel     = 2'd0;
      alu_src_b  = 2'd0;
      alu_code   = 6'd0;
      hilo_write = 1'b0;
      halt       = 1'b0;
      illegal    = 1'b0;
    end

    alu_op = ALU_OP_W'(alu_code);
  end

  assign state = rst_n ? cur_state : S_FETCH;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed, self-checking bench for mc_control.
// Expectations for MULT follow whether MC_CONTROL_MULDIV_EN is defined.
module tb_mc_control;

  localparam int MDC = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] func;
  logic [4:0] rt;
  logic       mem_ready;
  logic       alu_zero;
  logic       alu_neg;
  logic       mem_req, mem_we, mem_byte, iord, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       reg_write;
  logic [1:0] reg_dst, wb_sel, alu_src_b;
  logic [5:0] alu_op;
  logic       hilo_write, halt, illegal;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;
  logic [31:0] obs, exp;

  mc_control #(.ALU_OP_W(6), .MULDIV_CYCLES(MDC)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .rt(rt),
    .mem_ready(mem_ready), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .reg_dst(reg_dst), .wb_sel(wb_sel),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .hilo_write(hilo_write),
    .halt(halt), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  wire [27:0] all_outs = {mem_req, mem_we, mem_byte, iord, ir_write, pc_write,
                          pc_src, reg_write, reg_dst, wb_sel, alu_src_b, alu_op,
                          hilo_write, halt, illegal, state};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction in FETCH with mem_ready=1; returns in the DECODE cycle
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r);
    opcode = op; func = fn; rt = r; mem_ready = 1'b1;
    #1;
    cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = 6'b100011; func = 6'd0; rt = 5'd0;
    mem_ready = 1'b1; alu_zero = 1'b0; alu_neg = 1'b0;
    repeat (3) cyc();
    total++;
    if (all_outs !== 28'd0) begin
      bad++; $display("FAIL reset_outs got=%h want=%h", all_outs, 28'd0);
    end
    opcode = 6'b000000; func = 6'b100000;
    rst_n = 1'b1;
    #1;
    obs = {28'd0, state}; exp = 32'd0;
    total++;
    if ({state, mem_req} !== {4'd0, 1'b1}) begin
      bad++; $display("FAIL reset_release got=%h/%b want=0/1", state, mem_req);
    end
  endtask

  task automatic test_add();
    opcode = 6'b000000; func = 6'b100000; rt = 5'd0; mem_ready = 1'b1;
    #1;
    obs = {26'd0, state, iord, ir_write, pc_write, mem_req, pc_src};
    exp = {26'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL add_fetch got=%h want=%h", obs, exp); end
    cyc();
    total++;
    if (state !== 4'd1) begin bad++; $display("FAIL add_decode got=%0d want=1", state); end
    cyc();
    obs = {state, alu_op, alu_src_b}; exp = {4'd2, 6'b100000, 2'd0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL add_exec got=%h want=%h", obs, exp); end
    cyc();
    obs = {state, reg_write, reg_dst, wb_sel}; exp = {4'd5, 1'b1, 2'd1, 2'd0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL add_wb got=%h want=%h", obs, exp); end
    cyc();
    total++;
    if (state !== 4'd0) begin bad++; $display("FAIL add_next got=%0d want=0", state); end
  endtask

  task automatic test_lw_wait();
    issue(6'b100011, 6'd0, 5'd0);
    mem_ready = 1'b0;  // ignored in DECODE/EXEC
    #1;
    total++;
    if (state !== 4'd1) begin bad++; $display("FAIL lw_decode got=%0d want=1", state); end
    cyc();
    obs = {state, alu_op, alu_src_b}; exp = {4'd2, 6'b100000, 2'd1};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL lw_exec got=%h want=%h", obs, exp); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 2) mem_ready = 1'b1;
      #1;
      obs = {state, mem_req, iord, mem_we, mem_byte}; exp = {4'd3, 1'b1, 1'b1, 1'b0, 1'b0};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL lw_memrd%0d got=%h want=%h", i, obs, exp); end
    end
    cyc();
    obs = {state, reg_write, reg_dst, wb_sel}; exp = {4'd6, 1'b1, 2'd0, 2'd1};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL lw_wbmem got=%h want=%h", obs, exp); end
    cyc();
    total++;
    if (state !== 4'd0) begin bad++; $display("FAIL lw_next got=%0d want=0", state); end
  endtask

  task automatic test_branches();
    logic [5:0] ops [10];
    logic [4:0] rts [10];
    logic       zs  [10];
    logic       ns  [10];
    logic       tk  [10];
    ops = '{6'b000100, 6'b000100, 6'b000101, 6'b000101, 6'b000110,
            6'b000110, 6'b000111, 6'b000111, 6'b000001, 6'b000001};
    rts = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd1};
    zs  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ns  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tk  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      alu_zero = zs[i]; alu_neg = ns[i];
      issue(ops[i], 6'd0, rts[i]);
      cyc();
      obs = {state, pc_write, pc_src, alu_op, alu_src_b};
      exp = {4'd7, tk[i], 2'd1, 6'b100010, 2'd0};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL branch%0d got=%h want=%h", i, obs, exp); end
      cyc();
      total++;
      if (state !== 4'd0) begin bad++; $display("FAIL branch%0d_next got=%0d want=0", i, state); end
    end
    alu_zero = 1'b0; alu_neg = 1'b0;
  endtask

  task automatic test_jal();
    issue(6'b000011, 6'd0, 5'd0);
    cyc();
    obs = {state, pc_write, pc_src, reg_write, reg_dst, wb_sel};
    exp = {4'd8, 1'b1, 2'd2, 1'b1, 2'd2, 2'd2};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL jal_jump got=%h want=%h", obs, exp); end
    cyc();
    total++;
    if (state !== 4'd0) begin bad++; $display("FAIL jal_next got=%0d want=0", state); end
  endtask

  task automatic test_alu_ops();
    logic [5:0] ops [8];
    logic [5:0] fns [8];
    logic [5:0] aop [8];
    logic [1:0] src [8];
    ops = '{6'b001000, 6'b001001, 6'b001010, 6'b001100,
            6'b001101, 6'b001110, 6'b000000, 6'b000000};
    fns = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'b100010, 6'b100111};
    aop = '{6'b100000, 6'b100001, 6'b101010, 6'b100100,
            6'b100101, 6'b100110, 6'b100010, 6'b100111};
    src = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], fns[i], 5'd0);
      cyc();
      obs = {state, alu_op, alu_src_b}; exp = {4'd2, aop[i], src[i]};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL alu%0d_exec got=%h want=%h", i, obs, exp); end
      cyc();
      obs = {state, reg_write, reg_dst, wb_sel};
      exp = {4'd5, 1'b1, (ops[i] == 6'd0) ? 2'd1 : 2'd0, 2'd0};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL alu%0d_wb got=%h want=%h", i, obs, exp); end
      cyc();
    end
    issue(6'b001111, 6'd0, 5'd0);
    cyc();
    cyc();
    obs = {state, reg_write, reg_dst, wb_sel}; exp = {4'd5, 1'b1, 2'd0, 2'd3};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL lui_wb got=%h want=%h", obs, exp); end
    cyc();
  endtask

  task automatic test_illegal();
    issue(6'b111111, 6'd0, 5'd0);
    obs = {state, illegal}; exp = {4'd1, 1'b1};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL illegal_decode got=%h want=%h", obs, exp); end
    cyc();
    obs = {state, illegal}; exp = {4'd0, 1'b0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL illegal_next got=%h want=%h", obs, exp); end
  endtask

  task automatic test_muldiv();
    issue(6'b000000, 6'b011000, 5'd0);
`ifdef MC_CONTROL_MULDIV_EN
    obs = {state, illegal}; exp = {4'd1, 1'b0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL mult_decode got=%h want=%h", obs, exp); end
    cyc();
    obs = {state, alu_op, alu_src_b}; exp = {4'd2, 6'b011000, 2'd0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL mult_exec got=%h want=%h", obs, exp); end
    for (int i = 0; i < MDC; i++) begin
      cyc();
      obs = {state, hilo_write, alu_op}; exp = {4'd9, (i == MDC - 1), 6'b011000};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL mult_wait%0d got=%h want=%h", i, obs, exp); end
    end
    cyc();
    obs = {state, hilo_write}; exp = {4'd0, 1'b0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL mult_next got=%h want=%h", obs, exp); end
`else
    obs = {state, illegal, hilo_write}; exp = {4'd1, 1'b1, 1'b0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL mult_illegal got=%h want=%h", obs, exp); end
    cyc();
    obs = {state, illegal, hilo_write}; exp = {4'd0, 1'b0, 1'b0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL mult_next got=%h want=%h", obs, exp); end
`endif
  endtask

  task automatic test_store_reset();
    issue(6'b101000, 6'd0, 5'd0);
    cyc();
    mem_ready = 1'b0;
    cyc();
    obs = {state, mem_req, iord, mem_we, mem_byte}; exp = {4'd4, 1'b1, 1'b1, 1'b1, 1'b1};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL sb_memwr got=%h want=%h", obs, exp); end
    rst_n = 1'b0;
    #1;
    total++;
    if (all_outs !== 28'd0) begin bad++; $display("FAIL sb_rst_now got=%h want=0", all_outs); end
    cyc();
    total++;
    if (all_outs !== 28'd0) begin bad++; $display("FAIL sb_rst_held got=%h want=0", all_outs); end
    opcode = 6'b111111; mem_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    obs = {state, mem_req, mem_we, iord}; exp = {4'd0, 1'b1, 1'b0, 1'b0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL sb_release got=%h want=%h", obs, exp); end
    cyc();
    cyc();
  endtask

  task automatic test_syscall();
    issue(6'b000000, 6'b001100, 5'd0);
    obs = {state, illegal}; exp = {4'd1, 1'b0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL sys_decode got=%h want=%h", obs, exp); end
    for (int i = 0; i < 20; i++) begin
      cyc();
      obs = {state, halt, mem_req, ir_write}; exp = {4'd10, 1'b1, 1'b0, 1'b0};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL sys_halt%0d got=%h want=%h", i, obs, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_branches();
    test_jal();
    test_alu_ops();
    test_illegal();
    test_muldiv();
    test_store_reset();
    test_syscall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
